// File: rtl/spike_cmp_arbiter.sv
// spike_cmp_arbiter: shares one single-precision ">=" comparator among
// NUM_REQ neuron-update requesters through a two-stage pipeline
// (S0 operand register, S1 result register) with one response channel.
//
// Configuration macro: SPK_CMP_ARB_FIXED_PRIO_EN
//   defined   -> fixed priority, lowest asserted index wins (no rotate pointer)
//   undefined -> round-robin starting from the index after the last grant
//
// Handshake: every channel is valid/ready. A transfer happens on the rising
// edge where valid and ready are both high. A requester keeps req_valid and
// its operands stable until granted. req_ready is a combinational one-hot
// grant. resp_* stay stable while resp_valid is high and resp_ready is low.

// Combinational IEEE-754 single-precision A >= B. NaN inputs give an
// unspecified result. Equal operands give 1. -0 vs +0 gives 0.
module spike_cmp_fp_ge (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_ge
);

  // Sign first, then magnitude. The magnitude order flips for two negatives.
  always_comb begin
    o_ge = 1'b0;
    case ({i_a[31], i_b[31]})
      2'b00:   o_ge = (i_a[30:0] >= i_b[30:0]);
      2'b01:   o_ge = 1'b1;
      2'b10:   o_ge = 1'b0;
      default: o_ge = (i_a[30:0] <= i_b[30:0]);
    endcase
  end

endmodule

module spike_cmp_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic                   resp_greater,
  output logic                   busy
);

  // Stage S0: operands waiting for the comparator.
  logic            r_s0_valid;
  logic [31:0]     r_s0_a;
  logic [31:0]     r_s0_b;
  logic [ID_W-1:0] r_s0_id;

  // Stage S1: result presented on the response channel.
  logic            r_s1_valid;
  logic            r_s1_greater;
  logic [ID_W-1:0] r_s1_id;

  logic            w_s1_adv;
  logic            w_s0_load;
  logic            w_req_hit;
  logic            w_grant;
  logic [ID_W-1:0] w_grant_id;
  logic [31:0]     w_gnt_a;
  logic [31:0]     w_gnt_b;
  logic            w_ge;

  // S1 takes S0 whenever it is empty or being drained this cycle; S0 can
  // take a new request whenever it is empty or moving on, so a drain and a
  // refill in the same cycle never leave a bubble.
  assign w_s1_adv  = r_s0_valid & (~r_s1_valid | resp_ready);
  assign w_s0_load = ~r_s0_valid | w_s1_adv;

`ifdef SPK_CMP_ARB_FIXED_PRIO_EN

  // Fixed priority: the lowest asserted index wins.
  always_comb begin
    w_req_hit  = 1'b0;
    w_grant_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        w_req_hit  = 1'b1;
        w_grant_id = ID_W'(k);
      end
    end
  end

`else

  localparam logic [ID_W:0] LP_NUM = (ID_W + 1)'(NUM_REQ);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W:0]   w_idx;

  // Round-robin: first asserted request searching upward from r_ptr, wrapping.
  always_comb begin
    w_req_hit  = 1'b0;
    w_grant_id = '0;
    w_idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (ID_W + 1)'(k);
      if (w_idx >= LP_NUM) w_idx = w_idx - LP_NUM;
      if (!w_req_hit && req_valid[w_idx[ID_W-1:0]]) begin
        w_req_hit  = 1'b1;
        w_grant_id = w_idx[ID_W-1:0];
      end
    end
  end

  // Pointer moves to the index after each grant and holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_grant) begin
      r_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + 1'b1;
    end
  end

`endif

  // A grant needs a free S0 slot and is suppressed during reset.
  assign w_grant   = w_req_hit & w_s0_load & ~rst;
  assign req_ready = w_grant ? (NUM_REQ'(1) << w_grant_id) : '0;
  assign w_gnt_a   = req_a[32*w_grant_id +: 32];
  assign w_gnt_b   = req_b[32*w_grant_id +: 32];

  // S0 captures the granted operands, or empties when it moves on unreplaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s0_valid <= 1'b0;
      r_s0_a     <= '0;
      r_s0_b     <= '0;
      r_s0_id    <= '0;
    end else if (w_s0_load) begin
      r_s0_valid <= w_grant;
      if (w_grant) begin
        r_s0_a  <= w_gnt_a;
        r_s0_b  <= w_gnt_b;
        r_s0_id <= w_grant_id;
      end
    end
  end

  spike_cmp_fp_ge u_cmp (
    .i_a  (r_s0_a),
    .i_b  (r_s0_b),
    .o_ge (w_ge)
  );

  // S1 latches the comparator result, holds under backpressure, clears on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_s1_greater <= 1'b0;
      r_s1_id      <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid   <= 1'b1;
      r_s1_greater <= w_ge;
      r_s1_id      <= r_s0_id;
    end else if (resp_ready) begin
      r_s1_valid   <= 1'b0;
    end
  end

  assign resp_valid   = r_s1_valid;
  assign resp_id      = r_s1_id;
  assign resp_greater = r_s1_greater;
  assign busy         = r_s0_valid | r_s1_valid;

endmodule

// File: tb/tb_spike_cmp_arbiter.sv
// Testbench for spike_cmp_arbiter (NUM_REQ=4). Directed vectors come from a
// table; responses are checked by a negedge monitor against an expected queue.
module tb_spike_cmp_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int EW      = ID_W + 1;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic                  resp_greater;
  logic                  busy;

  spike_cmp_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_greater (resp_greater),
    .busy         (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- scoreboard ----------------
  int            n_checks = 0;
  int            n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  int            m_ptr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Float ordering via a monotonic unsigned key.
  function automatic logic fp_ge(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ka, kb;
    ka = a[31] ? ~a : (a | 32'h8000_0000);
    kb = b[31] ? ~b : (b | 32'h8000_0000);
    return ka >= kb;
  endfunction

  // Which requester the arbiter should pick given pending set and pointer.
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
    int idx;
`ifdef SPK_CMP_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (p + k) % NUM_REQ;
      if (v[idx]) return idx;
    end
`endif
    return 0;
  endfunction

  task automatic push_exp(input int id, input logic g);
    exp_q.push_back({ID_W'(id), g});
    m_ptr = (id + 1) % NUM_REQ;
  endtask

  // Pops one expectation per delivered response.
  always @(negedge clk) begin
    if (!rst && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_unexpected: got id %0d, expected no response at %0t", resp_id, $time);
      end else begin
        exp_e = exp_q.pop_front();
        check("resp_id", 32'(resp_id), 32'(exp_e[EW-1:1]));
        check("resp_greater", 32'(resp_greater), 32'(exp_e[0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_ops(input int id, input logic [31:0] a, input logic [31:0] b);
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
  endtask

  // Called shortly after a rising edge; returns one cycle after the grant.
  task automatic send_one(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic eg);
    int n;
    set_ops(id, a, b);
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[id] && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check("grant_onehot", 32'(req_ready), 32'(1) << id);
    if (req_ready[id]) push_exp(id, eg);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk); #2;
    check(name, 32'(exp_q.size()), 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = '0;
    exp_q.delete();
    @(posedge clk); #1;
    rst   = 1'b0;
    m_ptr = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic        exp_g;
  } vec_t;

  vec_t vecs[8];

  logic [31:0] ra, rb;
  int          gi;
  int          rid;
  logic [ID_W-1:0] snap_id;
  logic            snap_g;

  initial begin
    vecs[0] = '{0, 32'h3FC0_0000, 32'h3F80_0000, 1'b1};  //  1.5 >= 1.0
    vecs[1] = '{2, 32'hC000_0000, 32'h3F80_0000, 1'b0};  // -2.0 >= 1.0
    vecs[2] = '{2, 32'h3F80_0000, 32'h3F80_0000, 1'b1};  //  equal
    vecs[3] = '{1, 32'h3F80_0000, 32'h3FC0_0000, 1'b0};  //  1.0 >= 1.5
    vecs[4] = '{3, 32'hBF80_0000, 32'hC000_0000, 1'b1};  // -1.0 >= -2.0
    vecs[5] = '{3, 32'hC000_0000, 32'hBF80_0000, 1'b0};  // -2.0 >= -1.0
    vecs[6] = '{0, 32'h4049_0FDB, 32'h4049_0FDA, 1'b1};  // 1 ulp above
    vecs[7] = '{1, 32'h4049_0FDA, 32'h4049_0FDB, 1'b0};  // 1 ulp below

    rst        = 1'b1;
    req_valid  = '1;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;

    // Reset state; requests are ignored while rst is high.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_resp_greater", 32'(resp_greater), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst       = 1'b0;
    req_valid = '0;
    @(posedge clk); #1;

    // Directed table, first entry also measures latency.
    for (int i = 0; i < 8; i++) begin
      send_one(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp_g);
      if (i == 0) begin
        #1;
        check("lat_t1_valid", 32'(resp_valid), 32'd0);
        check("lat_t1_busy", 32'(busy), 32'd1);
        @(posedge clk); #2;
        check("lat_t2_valid", 32'(resp_valid), 32'd1);
        @(posedge clk); #2;
        check("lat_idle_busy", 32'(busy), 32'd0);
      end
    end
    wait_drain("table_drain");

    // Random single compares (normal numbers, some equal pairs).
    for (int i = 0; i < 6; i++) begin
      rid = $urandom_range(0, NUM_REQ - 1);
      ra  = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
      rb  = {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
      if ($urandom_range(0, 3) == 0) rb = ra;
      send_one(rid, ra, rb, fp_ge(ra, rb));
    end
    wait_drain("rand_drain");

    // Round-robin: all requesters held high for 8 grants.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, 32'h3F80_0000 + (32'(i) << 21), 32'h3FC0_0000);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
`ifdef SPK_CMP_ARB_FIXED_PRIO_EN
      gi = 0;
`else
      gi = k % NUM_REQ;
`endif
      check("rr_grant", 32'(req_ready), 32'(1) << gi);
      push_exp(gi, fp_ge(32'h3F80_0000 + (32'(gi) << 21), 32'h3FC0_0000));
      @(posedge clk); #1;
    end
    req_valid = '0;
    wait_drain("rr_drain");

    // Backpressure: requesters 1 and 3 stream, resp_ready low for 4 cycles.
    do_reset();
    set_ops(1, 32'h4000_0000, 32'h4040_0000);  // 2.0 >= 3.0 -> 0
    set_ops(3, 32'h40A0_0000, 32'hBF80_0000);  // 5.0 >= -1.0 -> 1
    resp_ready = 1'b0;
    req_valid  = 4'b1010;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (c < 2) begin
        gi = pick(req_valid, m_ptr);
        check("bp_accept", 32'(req_ready), 32'(1) << gi);
        push_exp(gi, (gi == 3));
        if (c == 1) check("bp_no_resp_yet", 32'(resp_valid), 32'd0);
      end else begin
        check("bp_full_ready", 32'(req_ready), 32'd0);
        check("bp_hold_valid", 32'(resp_valid), 32'd1);
        if (c == 2) begin
          check("bp_hold_id", 32'(resp_id), 32'(exp_q[0][EW-1:1]));
          snap_id = resp_id;
          snap_g  = resp_greater;
        end else begin
          check("bp_stable_id", 32'(resp_id), 32'(snap_id));
          check("bp_stable_greater", 32'(resp_greater), 32'(snap_g));
        end
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      gi = pick(req_valid, m_ptr);
      check("bp_release_grant", 32'(req_ready), 32'(1) << gi);
      push_exp(gi, (gi == 3));
      @(posedge clk); #1;
    end
    req_valid = '0;
    wait_drain("bp_drain");

    // Reset with both stages full: nothing stale afterwards, pointer back to 0.
    set_ops(1, 32'h3F80_0000, 32'h3F00_0000);  // 1.0 >= 0.5 -> 1
    set_ops(2, 32'h3F00_0000, 32'h3F80_0000);
    set_ops(3, 32'h3F00_0000, 32'h3F80_0000);  // 0.5 >= 1.0 -> 0
    resp_ready = 1'b0;
    req_valid  = 4'b0110;
    repeat (3) begin
      @(posedge clk); #1;
    end
    #1;
    check("mid_full_busy", 32'(busy), 32'd1);
    check("mid_full_valid", 32'(resp_valid), 32'd1);
    rst       = 1'b1;
    req_valid = 4'b1010;
    exp_q.delete();
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst        = 1'b0;
    resp_ready = 1'b1;
    m_ptr      = 0;
    #1;
    check("mid_post_valid", 32'(resp_valid), 32'd0);
    check("mid_post_busy", 32'(busy), 32'd0);
    gi = pick(req_valid, 0);
    check("mid_ptr_grant", 32'(req_ready), 32'(1) << gi);
    push_exp(gi, (gi == 1));
    @(posedge clk); #1;
    req_valid[gi] = 1'b0;
    #1;
    gi = pick(req_valid, m_ptr);
    check("mid_next_grant", 32'(req_ready), 32'(1) << gi);
    push_exp(gi, (gi == 1));
    @(posedge clk); #1;
    req_valid = '0;
    wait_drain("mid_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_cmp_arbiter.md
# spike_cmp_arbiter

Time-multiplexes one floating-point `comparator` instance among NUM_REQ neuron-update requesters for membrane-potential vs threshold checks. Each requester presents an IEEE-754 single-precision operand pair. The block grants one request per cycle and returns a tagged greater-or-equal result through a two-stage pipeline with a single shared response channel. It sits between the neuron state-update units and the spike generation logic in the accelerator.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..32).
- ID_W, $clog2(NUM_REQ): width of requester tag.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot grant. Transfer occurs when req_valid[i] & req_ready[i].
- req_a  in  NUM_REQ*32  operand A, requester i at bits [32i+31:32i] (membrane potential).
- req_b  in  NUM_REQ*32  operand B, same packing (threshold).
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  ID_W  index of the originating requester.
- resp_greater  out  1  1 when A ≥ B per comparator (sign of A−B is 0), else 0.
- busy  out  1  high while either pipeline stage holds a transaction.

## Operation
- Stage S0 register: s0_valid, s0_a, s0_b, s0_id. Comparator inputs are s0_a/s0_b only.
- Stage S1 register: s1_valid, s1_greater, s1_id. It drives the resp_* outputs directly.
- Advance rules:
  - s1_adv = s0_valid & (!s1_valid | resp_ready).
  - s0_load = !s0_valid | s1_adv.
  - If s1_valid & resp_ready & !s1_adv, then s1_valid clears.
- Arbitration: when s0_load is high, grant the first i with req_valid[i], searching from ptr upward modulo NUM_REQ. req_ready is the combinational one-hot of that grant and is all-zero when s0_load is low or no request is present.
- On a grant to i: S0 captures req_a[i], req_b[i], and i. ptr becomes (i+1) mod NUM_REQ.
- ptr holds when there is no grant.
- A requester holds req_valid and its operands stable until granted. req_valid must not be withdrawn before the grant.
- The arbiter never issues a grant to a requester whose req_valid is low.
- The equal-operand case yields resp_greater=1. +0 vs −0 yields whatever the comparator produces. NaN/Inf results are unspecified.
- Simultaneous S1 drain and S0 advance in the same cycle is legal and does not lose a bubble.

## Timing
- Latency: with request accepted in cycle t, resp_valid=1 in cycle t+2 when resp_ready was never low.
- Throughput: one grant per cycle under no backpressure.
- Backpressure:
  - With resp_ready low, S1 holds its result and resp_* stays stable.
  - S0 fills, then req_ready is all-zero.
  - At most 2 transactions are in flight.
- Reset values (cycle after rst sampled high):
  - s0_valid=0, s1_valid=0, ptr=0.
  - resp_valid=0, resp_id=0, resp_greater=0, busy=0.
  - req_ready=0 while rst is high.
- Reset mid-operation discards all in-flight transactions without emitting responses.
- The comparator path is combinational within one cycle, from the S0 register to the S1 register.

## Configuration
- SPK_CMP_ARB_FIXED_PRIO_EN defined: fixed priority, lowest asserted index wins. ptr is not implemented.
- Undefined (default): round-robin arbitration as described in Operation.

## Test plan
- Single compare: req 0 with A=0x3FC00000 (1.5), B=0x3F800000 (1.0), resp_ready=1. Expect resp_valid in cycle t+2 with resp_id=0, resp_greater=1, then busy=0.
- Sign and equality cases on req 2:
  - A=0xC0000000 (−2.0), B=0x3F800000 → greater=0.
  - A=B=0x3F800000 → greater=1.
- Round-robin: all 4 req_valid held high for 8 grants. Expect grant order 0,1,2,3,0,1,2,3 with resp_id following 2 cycles later. With SPK_CMP_ARB_FIXED_PRIO_EN defined, expect grants always 0.
- Backpressure:
  - Setup: stream on requesters 1 and 3 with resp_ready low for 4 cycles.
  - During the stall: req_ready goes all-zero after 2 accepts and resp_* stays stable.
  - After release: every result is delivered in order with no loss or duplication.
- Reset mid-operation: assert rst for one cycle with both stages full. Expect resp_valid=0 and busy=0 next cycle, no stale response afterwards, ptr=0 (next grant to lowest pending index ≥0).
